piso_serializer: RTL

//  Parallel-in/serial-out stage feeding the Mealy sequence detector's serial input (din).

---
 rtl/piso_serializer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out stage that feeds a bit-serial consumer such as the
//   Mealy sequence detector's din input. It accepts a WIDTH-bit word over a
//   valid/ready handshake and shifts it out one bit per clock. The next word
//   can be accepted on the last-bit cycle, so back-to-back words form one
//   continuous bit stream with no gap cycle between them.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   LSB_FIRST  0: pdata_in[WIDTH-1] is shifted first; 1: pdata_in[0] first
//   IDLE_LEVEL level driven on dout while no frame bit is being shifted
//
// Configuration macro
//   PISO_PARITY_EN  when defined, one even-parity bit (^word) is appended
//                   after the data bits, giving a frame of WIDTH+1 bits.
//                   When undefined, the frame is WIDTH bits and no parity
//                   logic is built.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   pdata_in    in   WIDTH  parallel word to serialize
//   load_valid  in   1      pdata_in holds a valid word
//   load_ready  out  1      word accepted this cycle if load_valid (combinational)
//   dout        out  1      serial bit stream (registered)
//   dout_valid  out  1      dout carries a frame bit this cycle (registered)
//   busy        out  1      frame in progress (registered)
//   done        out  1      high while the last frame bit is on dout (registered)
// -----------------------------------------------------------------------------
module piso_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          LSB_FIRST  = 1'b0,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pdata_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int unsigned FRAME_W = WIDTH + 1;
`else
   localparam int unsigned FRAME_W = WIDTH;
`endif
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [FRAME_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     word_ord_c;
   logic [FRAME_W-1:0]   frame_c;
   logic [CNT_W-1:0]     cnt_inc_c;
   logic                 last_bit_c;
   logic                 accept_c;

   // Reorder the word so that the bit to leave first always sits at the top.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (LSB_FIRST) begin : g_lsb
         assign word_ord_c[gi] = pdata_in[WIDTH-1-gi];
      end else begin : g_msb
         assign word_ord_c[gi] = pdata_in[gi];
      end
   end

   // Full frame image, first bit at index FRAME_W-1.
`ifdef PISO_PARITY_EN
   assign frame_c = {word_ord_c, ^pdata_in};
`else
   assign frame_c = word_ord_c;
`endif

   assign cnt_inc_c  = cnt_q + CNT_W'(1);
   assign last_bit_c = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
   assign accept_c   = load_valid && load_ready;

   // Ready in IDLE and on the last-bit cycle; this is what makes frames gapless.
   assign load_ready = (state_q == S_IDLE) || last_bit_c;

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      dout_d       = IDLE_LEVEL;
      dout_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               state_d      = S_SHIFT;
               cnt_d        = '0;
               dout_d       = frame_c[FRAME_W-1];
               shreg_d      = frame_c << 1;
               dout_valid_d = 1'b1;
               busy_d       = 1'b1;
            end
         end

         S_SHIFT: begin
            if (last_bit_c) begin
               if (accept_c) begin
                  // Next frame's first bit follows the current last bit directly.
                  cnt_d        = '0;
                  dout_d       = frame_c[FRAME_W-1];
                  shreg_d      = frame_c << 1;
                  dout_valid_d = 1'b1;
                  busy_d       = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  shreg_d = '0;
               end
            end else begin
               cnt_d        = cnt_inc_c;
               dout_d       = shreg_q[FRAME_W-1];
               shreg_d      = shreg_q << 1;
               dout_valid_d = 1'b1;
               busy_d       = 1'b1;
               done_d       = (cnt_inc_c == LAST_CNT);
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         dout_q       <= IDLE_LEVEL;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
